// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard sequencer.
package hazard_pkg;

  localparam int REG_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    UNUSED   = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bundle: pipeline observation inputs, register controls and debug outputs.
interface hazard_ctrl_if;
  import hazard_pkg::*;

  logic [REG_W-1:0] id_readREG1;
  logic [REG_W-1:0] id_readREG2;
  logic             id_uses_rt;
  logic             ex_MEMread;
  logic [REG_W-1:0] ex_writeREG;
  logic             branch_taken;
  logic             mem_access;
  logic             mem_ready;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_freeze;
  logic             mem_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_readREG1, id_readREG2, id_uses_rt, ex_MEMread, ex_writeREG,
           branch_taken, mem_access, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
           mem_err, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_readREG1, id_readREG2, id_uses_rt, ex_MEMread, ex_writeREG,
           branch_taken, mem_access, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
           mem_err, state, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones; one-cycle update latency, no backpressure.
module sat_counter
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipe: controls are combinational (act in the
// detection cycle), state and counters registered; a slow data memory freezes the back end.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int BR_PENALTY  = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hif
);

  localparam logic [2:0] FL_INIT = 3'(BR_PENALTY - 2);
  localparam logic [7:0] TMO     = 8'(MEM_TIMEOUT);

  hz_state_e  state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       pend_q, pend_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       err_q, err_d;

  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze;
  logic stall_inc, flush_inc;
  logic lu, mem_stall;

  assign lu = hif.ex_MEMread &
              ((hif.ex_writeREG == hif.id_readREG1) |
               (hif.id_uses_rt & (hif.ex_writeREG == hif.id_readREG2)));
  assign mem_stall = hif.mem_access & ~hif.mem_ready;

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    pend_d       = pend_q;
    wcnt_d       = wcnt_q;
    err_d        = err_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_freeze = 1'b1;
          stall_inc   = 1'b1;
          wcnt_d      = 8'd1;
          pend_d      = 1'b0;
          state_d     = MEM_WAIT;
        end else if (hif.branch_taken) begin
          // A coinciding load-use is dropped: the consumer in ID is being squashed anyway.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          flush_inc    = 1'b1;
          if (BR_PENALTY > 2) begin
            fcnt_d  = FL_INIT;
            state_d = FLUSH;
          end
        end else if (lu) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          stall_inc    = 1'b1;
        end
      end

      FLUSH: begin
        if (mem_stall) begin
          // Nothing was squashed this cycle, so the remaining count is kept as-is.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_freeze = 1'b1;
          stall_inc   = 1'b1;
          wcnt_d      = 8'd1;
          pend_d      = 1'b1;
          state_d     = MEM_WAIT;
        end else begin
          if_id_flush = 1'b1;
          if (fcnt_q <= 3'd1) state_d = RUN;
          else                fcnt_d  = fcnt_q - 3'd1;
        end
      end

      MEM_WAIT: begin
        if (hif.mem_ready) begin
          state_d = pend_q ? FLUSH : RUN;
          pend_d  = 1'b0;
        end else if (wcnt_q >= TMO) begin
          err_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = RUN;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_freeze = 1'b1;
          stall_inc   = 1'b1;
          wcnt_d      = wcnt_q + 8'd1;
        end
      end

      default: state_d = RUN;
    endcase

    // Reset forces idle controls immediately, without waiting for the state flop.
    if (rst) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_freeze  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  sat_counter u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (hif.stall_cnt)
  );

  sat_counter u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (hif.flush_cnt)
  );

  assign hif.pc_write     = pc_write;
  assign hif.if_id_write  = if_id_write;
  assign hif.if_id_flush  = if_id_flush;
  assign hif.id_ex_bubble = id_ex_bubble;
  assign hif.pipe_freeze  = pipe_freeze;
  assign hif.mem_err      = err_q;
  assign hif.state        = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with BR_PENALTY=3, MEM_TIMEOUT=15.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.BR_PENALTY(3), .MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  typedef struct {
    logic [2:0] rs;
    logic [2:0] rt;
    logic       uses_rt;
    logic       memread;
    logic [2:0] wreg;
    logic       macc;
    logic       mready;
    logic       exp_pcw;
    logic       exp_ifw;
    logic       exp_bub;
  } vec_t;

  vec_t vecs [10];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   exp_stall;
  int   exp_flush;
  int   frz_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic pcw, input logic ifw,
                         input logic fl, input logic bub, input logic frz);
    chk({tag, ".pc_write"},     {31'd0, hif.pc_write},     {31'd0, pcw});
    chk({tag, ".if_id_write"},  {31'd0, hif.if_id_write},  {31'd0, ifw});
    chk({tag, ".if_id_flush"},  {31'd0, hif.if_id_flush},  {31'd0, fl});
    chk({tag, ".id_ex_bubble"}, {31'd0, hif.id_ex_bubble}, {31'd0, bub});
    chk({tag, ".pipe_freeze"},  {31'd0, hif.pipe_freeze},  {31'd0, frz});
  endtask

  task automatic chk_state(input string tag, input int exp);
    chk({tag, ".state"}, {30'd0, hif.state}, exp);
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, ".stall_cnt"}, {24'd0, hif.stall_cnt}, exp_stall);
    chk({tag, ".flush_cnt"}, {24'd0, hif.flush_cnt}, exp_flush);
  endtask

  task automatic idle();
    hif.id_readREG1  = 3'd1;
    hif.id_readREG2  = 3'd2;
    hif.id_uses_rt   = 1'b0;
    hif.ex_MEMread   = 1'b0;
    hif.ex_writeREG  = 3'd0;
    hif.branch_taken = 1'b0;
    hif.mem_access   = 1'b0;
    hif.mem_ready    = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             rs    rt    urt   mrd   wreg  macc  mrdy  pcw   ifw   bub
    vecs[0] = '{3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{3'd1, 3'd3, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{3'd1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{3'd3, 3'd0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{3'd0, 3'd1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{3'd6, 3'd7, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{3'd1, 3'd2, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{3'd5, 3'd2, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{3'd4, 3'd6, 1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    idle();
    rst = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
    step();
    step();
    @(negedge clk);
    chk_state("reset", 0);
    chk_cnts("reset");
    chk("reset.mem_err", {31'd0, hif.mem_err}, 0);
    chk_ctl("reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk_ctl("idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Single-cycle vectors applied in RUN
    for (int i = 0; i < 10; i++) begin
      hif.id_readREG1 = vecs[i].rs;
      hif.id_readREG2 = vecs[i].rt;
      hif.id_uses_rt  = vecs[i].uses_rt;
      hif.ex_MEMread  = vecs[i].memread;
      hif.ex_writeREG = vecs[i].wreg;
      hif.mem_access  = vecs[i].macc;
      hif.mem_ready   = vecs[i].mready;
      @(negedge clk);
      chk_ctl($sformatf("vec%0d", i), vecs[i].exp_pcw, vecs[i].exp_ifw, 1'b0,
              vecs[i].exp_bub, 1'b0);
      if (vecs[i].exp_bub) exp_stall++;
      step();
      idle();
      chk_state($sformatf("vec%0d", i), 0);
      chk_cnts($sformatf("vec%0d", i));
    end

    // Branch: bubble+flush, one FLUSH cycle, back to RUN
    hif.branch_taken = 1'b1;
    @(negedge clk);
    chk_ctl("br.c0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    hif.branch_taken = 1'b0;
    exp_flush++;
    chk_state("br.c1", 1);
    chk_cnts("br.c1");
    @(negedge clk);
    chk_ctl("br.c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_state("br.c2", 0);
    @(negedge clk);
    chk_ctl("br.c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // A branch while in FLUSH must not count
    step();
    hif.branch_taken = 1'b1;
    step();
    exp_flush++;
    @(negedge clk);
    chk_ctl("brfl.c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    hif.branch_taken = 1'b0;
    chk_state("brfl.c2", 0);
    chk_cnts("brfl.c2");

    // Branch coinciding with load-use: flush only
    hif.branch_taken = 1'b1;
    hif.ex_MEMread   = 1'b1;
    hif.ex_writeREG  = 3'd4;
    hif.id_readREG1  = 3'd4;
    @(negedge clk);
    chk_ctl("brlu", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    exp_flush++;
    chk_cnts("brlu");
    chk_state("brlu", 1);
    step();
    chk_state("brlu.end", 0);

    // Memory wait: 4 freeze cycles, release on ready
    hif.mem_access = 1'b1;
    hif.mem_ready  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_ctl($sformatf("mw%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      chk_state($sformatf("mw%0d", i), 2);
    end
    hif.mem_ready = 1'b1;
    @(negedge clk);
    chk_ctl("mw.rdy", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    hif.mem_access = 1'b0;
    exp_stall += 4;
    chk_state("mw.end", 0);
    chk_cnts("mw.end");
    chk("mw.mem_err", {31'd0, hif.mem_err}, 0);

    // Memory wait interrupting FLUSH resumes the flush afterwards
    hif.branch_taken = 1'b1;
    step();
    hif.branch_taken = 1'b0;
    hif.mem_access   = 1'b1;
    hif.mem_ready    = 1'b0;
    @(negedge clk);
    chk_ctl("flmw.frz", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_state("flmw.wait", 2);
    hif.mem_ready = 1'b1;
    @(negedge clk);
    chk_ctl("flmw.rdy", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    hif.mem_access = 1'b0;
    chk_state("flmw.resume", 1);
    @(negedge clk);
    chk_ctl("flmw.resume", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    exp_stall += 1;
    exp_flush += 1;
    chk_state("flmw.end", 0);
    chk_cnts("flmw.end");

    // Memory wait beats a branch in the same cycle
    hif.branch_taken = 1'b1;
    hif.mem_access   = 1'b1;
    hif.mem_ready    = 1'b0;
    @(negedge clk);
    chk_ctl("mwbr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    hif.branch_taken = 1'b0;
    hif.mem_ready    = 1'b1;
    step();
    hif.mem_access = 1'b0;
    exp_stall += 1;
    chk_state("mwbr.end", 0);
    chk_cnts("mwbr.end");

    // Timeout after 15 freeze cycles
    hif.mem_access = 1'b1;
    hif.mem_ready  = 1'b0;
    frz_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hif.pipe_freeze !== 1'b1) break;
      frz_cycles++;
      step();
    end
    chk("tmo.freeze_cycles", frz_cycles, 15);
    chk("tmo.mem_err_pre", {31'd0, hif.mem_err}, 0);
    chk_state("tmo.last", 2);
    step();
    hif.mem_access = 1'b0;
    hif.mem_ready  = 1'b1;
    exp_stall += 15;
    chk("tmo.mem_err", {31'd0, hif.mem_err}, 1);
    chk_state("tmo.end", 0);
    chk_cnts("tmo.end");
    step();
    step();
    chk("tmo.sticky", {31'd0, hif.mem_err}, 1);

    // Asynchronous reset in the middle of MEM_WAIT
    hif.mem_access = 1'b1;
    hif.mem_ready  = 1'b0;
    step();
    step();
    chk_state("rstmw.pre", 2);
    #2;
    rst = 1'b1;
    #1;
    exp_stall = 0;
    exp_flush = 0;
    chk_state("rstmw", 0);
    chk_cnts("rstmw");
    chk("rstmw.mem_err", {31'd0, hif.mem_err}, 0);
    chk_ctl("rstmw", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    step();

    // Saturation of both counters
    hif.ex_MEMread  = 1'b1;
    hif.ex_writeREG = 3'd2;
    hif.id_readREG1 = 3'd2;
    repeat (260) step();
    idle();
    chk("sat.stall_cnt", {24'd0, hif.stall_cnt}, 255);
    for (int i = 0; i < 260; i++) begin
      hif.branch_taken = 1'b1;
      step();
      hif.branch_taken = 1'b0;
      step();
    end
    chk("sat.flush_cnt", {24'd0, hif.flush_cnt}, 255);
    chk_state("sat.end", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
